// File: rtl/sim_run_ctrl.sv
// Bring-up run controller: preloads a config table into byte RAM, holds the cores
// in reset, runs them for a chunked cycle budget with early exit on all-done, and
// then streams a RAM window out to a dump consumer.
module sim_run_ctrl #(
  parameter int unsigned N_CORES      = 1,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned INIT_WORDS   = 9,
  parameter int unsigned INIT_BASE    = 40960,
  parameter int unsigned RST_HOLD     = 12,
  parameter int unsigned CHUNK_CYCLES = 10000,
  parameter int unsigned N_CHUNKS     = 100,
  parameter int unsigned DUMP_BASE    = 0,
  parameter int unsigned DUMP_WORDS   = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [32*INIT_WORDS-1:0]      init_table_i,
  output logic                          mem_we_o,
  output logic                          mem_re_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [7:0]                    mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [7:0]                    mem_rdata_i,
  output logic [N_CORES-1:0]            core_rst_n_o,
  input  logic [N_CORES-1:0]            core_done_i,
  output logic [$clog2(N_CHUNKS+1)-1:0] progress_o,
  output logic                          progress_p_o,
  output logic                          dump_valid_o,
  input  logic                          dump_ready_i,
  output logic [ADDR_W-1:0]             dump_addr_o,
  output logic [7:0]                    dump_data_o,
  output logic                          dump_last_o,
  output logic                          busy_o,
  output logic                          finished_o,
  output logic                          timeout_o
);

  localparam int unsigned PW     = $clog2(N_CHUNKS + 1);
  localparam int unsigned NBytes = 4 * INIT_WORDS;
  localparam logic [ADDR_W-1:0] InitBaseA = ADDR_W'(INIT_BASE);
  localparam logic [ADDR_W-1:0] DumpBaseA = ADDR_W'(DUMP_BASE);

  // Dump is split into request / wait-for-data / present so only one read is in flight.
  typedef enum logic [2:0] {
    StIdle, StPreload, StHold, StRun, StDumpReq, StDumpWait, StDumpOut, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     idx_q, idx_d;    // preload byte index, hold count or dump index
  logic [31:0]     cyc_q, cyc_d;    // cycle within the current run chunk
  logic [PW-1:0]   progress_q, progress_d;
  logic            pulse_q, pulse_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      init_byte;
  logic            run_wrap, budget_hit, all_done;

  assign run_wrap   = (cyc_q == CHUNK_CYCLES - 1);
  assign budget_hit = (32'(progress_q) + 32'd1 >= N_CHUNKS);
  assign all_done   = &core_done_i;

  // Little-endian byte select: byte j of the table sits at bits [8j+7:8j].
  always_comb begin
    init_byte = '0;
    for (int j = 0; j < int'(NBytes); j++) begin
      if (idx_q == 32'(j)) init_byte = init_table_i[8*j +: 8];
    end
  end

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    progress_d = progress_q;
    pulse_d    = 1'b0;
    timeout_d  = timeout_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StPreload;
          idx_d      = '0;
          progress_d = '0;
          timeout_d  = 1'b0;
        end
      end
      StPreload: begin
        if (mem_gnt_i) begin
          if (idx_q == NBytes - 1) begin
            idx_d   = '0;
            cyc_d   = '0;
            state_d = (RST_HOLD == 0) ? StRun : StHold;
          end else begin
            idx_d = idx_q + 32'd1;
          end
        end
      end
      StHold: begin
        if (idx_q == RST_HOLD - 1) begin
          idx_d   = '0;
          cyc_d   = '0;
          state_d = StRun;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      StRun: begin
        if (run_wrap) begin
          cyc_d      = '0;
          progress_d = progress_q + PW'(1);
          pulse_d    = 1'b1;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
        // All-done takes priority over budget exhaustion in the same cycle.
        if (all_done) begin
          state_d   = StDumpReq;
          timeout_d = 1'b0;
          idx_d     = '0;
        end else if (run_wrap && budget_hit) begin
          state_d   = StDumpReq;
          timeout_d = 1'b1;
          idx_d     = '0;
        end
      end
      StDumpReq: begin
        if (mem_gnt_i) state_d = StDumpWait;
      end
      StDumpWait: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = StDumpOut;
        end
      end
      StDumpOut: begin
        if (dump_ready_i) begin
          if (idx_q == DUMP_WORDS - 1) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 32'd1;
            state_d = StDumpReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cyc_q      <= '0;
      progress_q <= '0;
      pulse_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      progress_q <= progress_d;
      pulse_q    <= pulse_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs decoded from the current state; idle values are all zero.
  always_comb begin
    mem_we_o     = (state_q == StPreload);
    mem_re_o     = (state_q == StDumpReq);
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    dump_valid_o = (state_q == StDumpOut);
    dump_addr_o  = '0;
    dump_data_o  = '0;
    dump_last_o  = 1'b0;
    if (state_q == StPreload) begin
      mem_addr_o  = InitBaseA + idx_q[ADDR_W-1:0];
      mem_wdata_o = init_byte;
    end
    if (state_q == StDumpReq) mem_addr_o = DumpBaseA + idx_q[ADDR_W-1:0];
    if (state_q == StDumpOut) begin
      dump_addr_o = DumpBaseA + idx_q[ADDR_W-1:0];
      dump_data_o = rdata_q;
      dump_last_o = (idx_q == DUMP_WORDS - 1);
    end
  end

  assign core_rst_n_o = (state_q == StRun) ? {N_CORES{1'b1}} : {N_CORES{1'b0}};
  assign progress_o   = progress_q;
  assign progress_p_o = pulse_q;
  assign timeout_o    = timeout_q;
  assign finished_o   = (state_q == StDone);
  assign busy_o       = (state_q != StIdle) && (state_q != StDone);

endmodule
